// File: rtl/reg_bank_write_arbiter_if.sv
// reg_bank_write_arbiter_if: requester-side and bank-side signals of the register-bank write arbiter
//   master modport (requesters/bench): drives req, addr, wdata; observes gnt, grant_id, busy, addr_err, reg_en, reg_d
//   slave modport (arbiter): reads req, addr, wdata; drives gnt, grant_id, reg_en, reg_d, busy, addr_err
//   addr slice i = [i*AW +: AW], wdata slice i = [i*W +: W]
interface reg_bank_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int N_REG = 8
);
    localparam int AW = $clog2(N_REG);
    localparam int IW = $clog2(N_REQ);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*W-1:0]  wdata;
    logic [N_REQ-1:0]    gnt;
    logic [IW-1:0]       grant_id;
    logic [N_REG-1:0]    reg_en;
    logic [W-1:0]        reg_d;
    logic                busy;
    logic                addr_err;
    modport master (
        output req, addr, wdata,
        input  gnt, grant_id, reg_en, reg_d, busy, addr_err
    );
    modport slave (
        input  req, addr, wdata,
        output gnt, grant_id, reg_en, reg_d, busy, addr_err
    );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter: round-robin arbiter granting one of N_REQ writers per cycle onto a shared N_REG x W register bank
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   bus (slave)     req/addr/wdata in; gnt, grant_id, reg_en, reg_d, busy, addr_err out (all registered)
//   Optional REG_ARB_BURST_EN: adds MAX_BURST; the grant holder keeps the bus while requesting, yielding
//   after MAX_BURST consecutive grants only if another requester is pending.
module reg_bank_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int W         = 8,
    parameter int N_REG     = 8
`ifdef REG_ARB_BURST_EN
    ,
    parameter int MAX_BURST = 4
`endif
) (
    input logic clk,
    input logic rst,
    reg_bank_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(N_REG);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic [N_REG-1:0] reg_en_q, reg_en_d;
    logic [W-1:0]     reg_d_q, reg_d_d;
    logic             addr_err_q, addr_err_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] elig;
    logic [IW-1:0]    win;
    logic [AW-1:0]    waddr;
    logic             any, addr_ok;
`ifdef REG_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0]    burst_q, burst_d;
    logic             keep;
`endif

    // First eligible index at or after p (mod N_REQ); scanning downward lets the nearest one win.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] e, input logic [IW-1:0] p);
        rr_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (e[(int'(p) + k) % N_REQ]) rr_pick = IW'((int'(p) + k) % N_REQ);
    endfunction

    always_comb begin
`ifdef REG_ARB_BURST_EN
        // burst_q counts repeat grants after the first; at MAX_BURST-1 the holder yields only to a pending rival
        keep = |(bus.req & gnt_q) && (burst_q != BW'(MAX_BURST - 1) || (bus.req & ~gnt_q) == '0);
        elig = keep ? gnt_q : bus.req & ~gnt_q;
`else
        // a requester just granted sits out one arbitration, so held requests rotate
        elig = bus.req & ~gnt_q;
`endif
        any        = |elig;
        win        = rr_pick(elig, rr_ptr_q);
        waddr      = bus.addr[int'(win)*AW +: AW];
        addr_ok    = int'(waddr) < N_REG;
        state_d    = any ? GRANT : IDLE;
        gnt_d      = '0;
        reg_en_d   = '0;
        if (any) gnt_d[win] = 1'b1;
        if (any && addr_ok) reg_en_d[waddr] = 1'b1;
        grant_id_d = any ? win : grant_id_q;
        reg_d_d    = any ? bus.wdata[int'(win)*W +: W] : reg_d_q;
        addr_err_d = any && !addr_ok;
`ifdef REG_ARB_BURST_EN
        rr_ptr_d   = (any && !keep) ? IW'((int'(win) + 1) % N_REQ) : rr_ptr_q;
        burst_d    = (keep && burst_q != BW'(MAX_BURST - 1)) ? burst_q + 1'b1 : '0;
`else
        rr_ptr_d   = any ? IW'((int'(win) + 1) % N_REQ) : rr_ptr_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            grant_id_q <= '0;
            reg_en_q   <= '0;
            reg_d_q    <= '0;
            addr_err_q <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            grant_id_q <= grant_id_d;
            reg_en_q   <= reg_en_d;
            reg_d_q    <= reg_d_d;
            addr_err_q <= addr_err_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef REG_ARB_BURST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) burst_q <= '0;
        else     burst_q <= burst_d;
    end
`endif

    assign bus.gnt      = gnt_q;
    assign bus.grant_id = grant_id_q;
    assign bus.reg_en   = reg_en_q;
    assign bus.reg_d    = reg_d_q;
    assign bus.busy     = state_q == GRANT;
    assign bus.addr_err = addr_err_q;
endmodule
